// File: rtl/conv_pkg.sv
// Shared constants and element-packing helper for the 3x3 window / matrix-multiply path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 3;
    localparam int WIN_W = WIN_N * WIN_N * PIX_W;

    // Bit offset of window element (i,j); i=0 is the top row, j=0 the leftmost column.
    function automatic int win_idx(input int i, input int j);
        return (i * WIN_N + j) * PIX_W;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage indexed by column; read returns the old word at addr.
// Latency: combinational read, write lands on the rising edge when en is high.
// Backpressure: none; the caller gates en with its own accept condition.
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat
);

    // Contents are never reset: the window gating upstream masks anything stale.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read-before-write: the read is combinational from the pre-edge contents.
    assign rd_dat = mem_q[addr];

    // Write the new word for this column on an accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Builds valid-region 3x3 sliding windows from a raster pixel stream using two line buffers.
// Latency: 1 cycle from the accept of a window's bottom-right pixel to win_valid.
// Backpressure: pix_ready drops while a window is held (win_valid && !win_ready); all state freezes.
module window_3x3_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [7:0]         win_row,
    output logic [7:0]         win_col,
    output logic               frame_done
);

    import conv_pkg::WIN_N;

    localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);

    logic [7:0]         col_q, col_d;
    logic [7:0]         row_q, row_d;
    logic [PIX_W-1:0]   win_q [WIN_N][WIN_N];
    logic [PIX_W-1:0]   win_d [WIN_N][WIN_N];
    logic [9*PIX_W-1:0] win_out_q, win_out_d;
    logic               win_valid_q, win_valid_d;
    logic [7:0]         win_row_q, win_row_d;
    logic [7:0]         win_col_q, win_col_d;
    logic               frame_done_q, frame_done_d;

    logic               accept;
    logic               emit;
    logic [PIX_W-1:0]   lb0_rd;
    logic [PIX_W-1:0]   lb1_rd;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    // Only a pixel at row>=2, col>=2 completes a window made entirely of this frame's data.
    assign emit      = accept && (row_q >= 8'd2) && (col_q >= 8'd2);

    // lb0 holds the previous line; lb1 is fed from lb0's old word, so it trails by one more line.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .en     (accept),
        .addr   (col_q[AW-1:0]),
        .wr_dat (pix_in),
        .rd_dat (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .en     (accept),
        .addr   (col_q[AW-1:0]),
        .wr_dat (lb0_rd),
        .rd_dat (lb1_rd)
    );

    // Raster position: column wraps at end of line, row wraps at end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Shift the window one column left and load the new column from the line buffers and pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < WIN_N; i++) begin
                for (int j = 0; j < WIN_N - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            win_d[0][WIN_N-1] = lb1_rd;
            win_d[1][WIN_N-1] = lb0_rd;
            win_d[2][WIN_N-1] = pix_in;
        end
    end

    // Output register: capture a completed window, or drop valid once the consumer has taken it.
    always_comb begin
        win_out_d    = win_out_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        if (emit) begin
            for (int i = 0; i < WIN_N; i++) begin
                for (int j = 0; j < WIN_N; j++) begin
                    win_out_d[(i*WIN_N + j)*PIX_W +: PIX_W] = win_d[i][j];
                end
            end
            win_valid_d  = 1'b1;
            win_row_d    = row_q - 8'd2;
            win_col_d    = col_q - 8'd2;
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                for (int j = 0; j < WIN_N; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            win_out_q    <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_out_q    <= win_out_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_out    = win_out_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: 4x4, 8x8 and 3x3 instances share one stimulus bus.
// Latency: expectations come from a frame-array reference model, not from the DUT.
// Backpressure: random and forced win_ready stalls are applied and checked.
module tb_window_3x3_gen;

    import conv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       win_ready;

    logic        pr [3];
    logic [71:0] wo [3];
    logic        wv [3];
    logic [7:0]  wr [3];
    logic [7:0]  wc [3];
    logic        fd [3];

    window_3x3_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr[0]),
        .win_out(wo[0]), .win_valid(wv[0]), .win_ready(win_ready),
        .win_row(wr[0]), .win_col(wc[0]), .frame_done(fd[0]));

    window_3x3_gen #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) dut8 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr[1]),
        .win_out(wo[1]), .win_valid(wv[1]), .win_ready(win_ready),
        .win_row(wr[1]), .win_col(wc[1]), .frame_done(fd[1]));

    window_3x3_gen #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) dut3 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr[2]),
        .win_out(wo[2]), .win_valid(wv[2]), .win_ready(win_ready),
        .win_row(wr[2]), .win_col(wc[2]), .frame_done(fd[2]));

    int          sel;
    logic        o_pix_ready;
    logic [71:0] o_win_out;
    logic        o_win_valid;
    logic [7:0]  o_win_row;
    logic [7:0]  o_win_col;
    logic        o_frame_done;

    // Observe the instance under test.
    always_comb begin
        o_pix_ready  = pr[0];
        o_win_out    = wo[0];
        o_win_valid  = wv[0];
        o_win_row    = wr[0];
        o_win_col    = wc[0];
        o_frame_done = fd[0];
        case (sel)
            1: begin
                o_pix_ready = pr[1]; o_win_out = wo[1]; o_win_valid = wv[1];
                o_win_row = wr[1]; o_win_col = wc[1]; o_frame_done = fd[1];
            end
            2: begin
                o_pix_ready = pr[2]; o_win_out = wo[2]; o_win_valid = wv[2];
                o_win_row = wr[2]; o_win_col = wc[2]; o_frame_done = fd[2];
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [WIN_W-1:0] win;
        int               row;
        int               col;
        bit               last;
    } exp_t;

    int   stream [$];
    exp_t exp_q  [$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: every valid-region window of a w x h frame stored at stream[base].
    function automatic void push_expected(input int base, input int w, input int h);
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                exp_t e;
                e.win = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        e.win[win_idx(i, j) +: 8] = 8'(stream[base + (r + i) * w + (c + j)]);
                    end
                end
                e.row  = r;
                e.col  = c;
                e.last = (r == h - 3) && (c == w - 3);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic apply_reset();
        rst       = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        pix_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic prepare(input int s);
        sel = s;
        stream.delete();
        exp_q.delete();
        apply_reset();
    endtask

    // Drive the stream and score every handshake against exp_q.
    task automatic run_stream(input string tag, input int vprob, input int rprob, input int hold_cycles);
        int   idx       = 0;
        int   n         = stream.size();
        int   hold_left = 0;
        bit   hold_done = 1'b0;
        bit   prev_hold = 1'b0;
        int   budget    = 0;
        exp_t e;
        while (exp_q.size() > 0 && budget < 4000) begin
            @(posedge clk);
            #1;
            budget++;
            vectors++;
            if (o_win_valid && !prev_hold) begin
                if (o_frame_done !== exp_q[0].last) begin
                    miscompares++;
                    $display("FAIL %s frame_done on new window (%0d,%0d): got %0b want %0b",
                             tag, exp_q[0].row, exp_q[0].col, o_frame_done, exp_q[0].last);
                end
            end else if (o_frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s frame_done without new window: got %0b want 0", tag, o_frame_done);
            end
            if (hold_cycles > 0 && !hold_done && o_win_valid) begin
                hold_left = hold_cycles;
                hold_done = 1'b1;
            end
            pix_valid = (idx < n) && ($urandom_range(99) < vprob);
            pix_in    = (idx < n) ? 8'(stream[idx]) : 8'h00;
            win_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
            #1;
            if (hold_left > 0) begin
                vectors++;
                if (o_pix_ready !== 1'b0 || o_win_valid !== 1'b1 || o_win_out !== exp_q[0].win) begin
                    miscompares++;
                    $display("FAIL %s hold: pix_ready=%0b win_valid=%0b win_out=%h want pix_ready=0 win_valid=1 win_out=%h",
                             tag, o_pix_ready, o_win_valid, o_win_out, exp_q[0].win);
                end
                hold_left--;
            end
            if (pix_valid && o_pix_ready) idx++;
            prev_hold = o_win_valid && !win_ready;
            if (o_win_valid && win_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (o_win_out !== e.win || o_win_row !== 8'(e.row) || o_win_col !== 8'(e.col)) begin
                    miscompares++;
                    $display("FAIL %s window: got %h row %0d col %0d want %h row %0d col %0d",
                             tag, o_win_out, o_win_row, o_win_col, e.win, e.row, e.col);
                end
            end
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d windows still expected", tag, exp_q.size());
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        vectors++;
        if (idx != n) begin
            miscompares++;
            $display("FAIL %s pixels accepted: got %0d want %0d", tag, idx, n);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            vectors++;
            if (o_win_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s extra window: got win_valid=1 row %0d col %0d want win_valid=0",
                         tag, o_win_row, o_win_col);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if (o_pix_ready !== 1'b1 || o_win_valid !== 1'b0 || o_win_out !== '0 ||
            o_win_row !== 8'd0 || o_win_col !== 8'd0 || o_frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s reset state: pix_ready=%0b win_valid=%0b win_out=%h row=%0d col=%0d frame_done=%0b want 1,0,0,0,0,0",
                     tag, o_pix_ready, o_win_valid, o_win_out, o_win_row, o_win_col, o_frame_done);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            prepare(s);
            check_idle($sformatf("reset_dut%0d", s));
        end
    endtask

    task automatic test_basic();
        prepare(0);
        for (int k = 0; k < 16; k++) stream.push_back(k + 1);
        push_expected(0, 4, 4);
        run_stream("basic_4x4", 100, 100, 0);
    endtask

    task automatic test_hold();
        prepare(0);
        for (int k = 0; k < 16; k++) stream.push_back(k + 1);
        push_expected(0, 4, 4);
        run_stream("hold_4x4", 100, 100, 5);
    endtask

    task automatic test_random();
        prepare(1);
        for (int k = 0; k < 64; k++) stream.push_back(k + 1);
        push_expected(0, 8, 8);
        run_stream("random_8x8", 50, 50, 0);
    endtask

    task automatic test_back_to_back();
        prepare(0);
        for (int k = 0; k < 16; k++) stream.push_back(k + 1);
        for (int k = 0; k < 16; k++) stream.push_back(101 + k);
        push_expected(0, 4, 4);
        push_expected(16, 4, 4);
        run_stream("back_to_back", 100, 100, 0);
    endtask

    task automatic test_mid_reset();
        prepare(0);
        win_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(200 + k);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_idle("mid_reset_async");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 16; k++) stream.push_back(k + 1);
        push_expected(0, 4, 4);
        run_stream("after_mid_reset", 100, 100, 0);
    endtask

    task automatic test_3x3();
        prepare(2);
        for (int k = 0; k < 9; k++) stream.push_back(k + 1);
        push_expected(0, 3, 3);
        run_stream("tiny_3x3", 100, 100, 0);
        vectors++;
        if (o_pix_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tiny_3x3 pix_ready after window: got %0b want 1", o_pix_ready);
        end
    endtask

    initial begin
        sel       = 0;
        rst       = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        pix_in    = 8'h00;
        test_reset();
        test_basic();
        test_hold();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_3x3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream feeder for the 3x3 matrix-multiply/convolution stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per handshake, and builds 3x3 sliding windows with two line buffers.
- Emits each window as a 72-bit packed word, in the same element packing the multiply stage consumes on its `a` operand.
- Valid-region only: no padding; each frame yields (IMG_W-2)*(IMG_H-2) windows.

Parameters:
- IMG_W, 8, pixels per line; legal range 3..256.
- IMG_H, 8, lines per frame; legal range 3..256.
- PIX_W, 8, pixel width in bits; the window is 9*PIX_W bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pix_in  input  PIX_W  input pixel.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- win_out  output  9*PIX_W  window; element (i,j) at bits [(i*3+j)*PIX_W +: PIX_W]. i=0 is the oldest (top) row; j=0 is the leftmost column.
- win_valid  output  1  win_out holds a window.
- win_ready  input  1  downstream accepts the window.
- win_row  output  8  top-left row coordinate of the current window.
- win_col  output  8  top-left column coordinate of the current window.
- frame_done  output  1  one-cycle pulse on the cycle the last window of a frame becomes valid.

Behaviour:
- Accept: a pixel is accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (combinational, from registered win_valid).
- Counters: col counts 0..IMG_W-1, row counts 0..IMG_H-1. On each accept, col increments; at col==IMG_W-1 col wraps to 0 and row increments; at row==IMG_H-1 && col==IMG_W-1 both wrap to 0.
- Line buffers: lb0 holds the previous line, lb1 the line before that; each is IMG_W deep, indexed by col. On accept, read lb1[col] and lb0[col], then write lb1[col] <= lb0[col] and lb0[col] <= pix_in.
- Window register: a 3x3 array shifts one column left on each accept. The new rightmost column (j=2) is {i=0: lb1[col], i=1: lb0[col], i=2: pix_in}. The window does not shift when there is no accept.
- Emit rule: on an accept with row>=2 && col>=2, win_out updates and win_valid is 1 the next cycle. Latency is 1 cycle from the accept to win_valid. win_row = row-2 and win_col = col-2, registered with win_out.
- Accepts with row<2 or col<2 shift the window and line buffers but do not raise win_valid. A window is therefore never built from previous-line or stale data.
- win_valid clears after a cycle with win_ready=1 and no new qualifying accept. A qualifying accept in the same cycle as win_ready keeps win_valid=1 with the new window, giving back-to-back throughput of 1 window/cycle.
- Hold: while win_valid && !win_ready, win_out, win_row, win_col and win_valid are stable, pix_ready=0, and the counters are frozen.
- frame_done is 1 for exactly the cycle win_valid rises for window (IMG_H-3, IMG_W-3). It is 0 otherwise.
- Frames run back-to-back with no gap cycle required. Line buffers are not cleared at a frame wrap; the row<2 gating masks stale contents.
- Reset values: row=0, col=0, window regs=0, win_out=0, win_valid=0, win_row=0, win_col=0, frame_done=0. pix_ready is 1 out of reset. Line buffer contents are don't-care after reset and never observable.
- Reset mid-frame: all state returns to the reset values immediately; the next accepted pixel is treated as pixel (0,0) of a new frame.
- Gaps: pix_valid=0 bubbles are permitted anywhere and change no state.

Decomposition:
- Shared package conv_pkg:
  - constants PIX_W=8, WIN_N=3, WIN_W=WIN_N*WIN_N*PIX_W=72;
  - function win_idx(i,j) returning (i*3+j)*PIX_W.
- The multiply stage uses the same package.
- Sub-module line_buffer (params DEPTH, WIDTH): synchronous write, read-before-write at the same address, enable input. Instantiated twice.

Test Plan:
- 4x4 frame, pixel(r,c)=r*4+c+1, win_ready=1, pix_valid=1 continuously:
  - first window bytes [0..8] = 1,2,3,5,6,7,9,10,11 with win_row=0, win_col=0;
  - then 2,3,4,6,7,8,10,11,12; then 5,6,7,9,10,11,13,14,15; then 6,7,8,10,11,12,14,15,16;
  - exactly 4 windows; frame_done with the 4th.
- Same 4x4 frame with win_ready held 0 for 5 cycles after the first win_valid:
  - pix_ready=0 and win_out stable (=1,2,3,5,6,7,9,10,11) throughout;
  - after release, the remaining windows are unchanged and in order; no pixel lost or duplicated.
- Random pix_valid bubbles (50%) and random win_ready on an 8x8 ramp frame: 36 windows, each matching the reference model; frame_done once.
- Two back-to-back 4x4 frames, the second with pixel = 100+index: first window of frame 2 = 101,102,103,105,106,107,109,110,111; no window emitted before its row 2, col 2.
- rst asserted mid-frame 1 (after 7 pixels), then a full clean 4x4 frame: outputs identical to the first scenario; no window from pre-reset pixels.
- IMG_W=3, IMG_H=3 with pixels 1..9: exactly one window 1..9 with frame_done; pix_ready=1 again next cycle with win_ready=1.
